// File: rtl/hssl_rx_link_sync.sv
// hssl_rx_link_sync: receive-side link synchroniser for the HSSL.
// Classifies 8b10b words from the GT, tracks link sync using idle commas,
// forwards data words through a small first-word-fall-through FIFO and
// requests a GT RX datapath reset after a prolonged loss of sync.
// Optional statistics counters are built when HSSL_RX_STATS_EN is defined;
// otherwise err_cnt_out and drop_cnt_out are tied to zero.
// FIFO_DEPTH_LOG2 must be at least 1.
module hssl_rx_link_sync #(
  parameter int SYNC_COMMA_CNT  = 8,
  parameter int LOS_ERR_THRESH  = 4,
  parameter int RESET_TIMEOUT   = 65535,
  parameter int FIFO_DEPTH_LOG2 = 2
) (
  input  logic        clk_in,
  input  logic        reset_n_in,
  input  logic [31:0] rx_data_in,
  input  logic [3:0]  rx_charisk_in,
  input  logic [3:0]  rx_disperr_in,
  input  logic [3:0]  rx_encerr_in,
  input  logic        rx_bufstatus_in,
  input  logic        rx_reset_done_in,
  output logic        rx_reset_datapath_out,
  output logic [31:0] data_out,
  output logic        vld_out,
  input  logic        rdy_in,
  output logic        link_up_out,
  output logic [1:0]  state_out,
  output logic [15:0] err_cnt_out,
  output logic [15:0] drop_cnt_out
);

  localparam int Depth  = 1 << FIFO_DEPTH_LOG2;
  localparam int TimerW = $clog2(RESET_TIMEOUT + 1);

  typedef enum logic [1:0] {
    StLoss    = 2'b00,
    StAcquire = 2'b01,
    StSync    = 2'b10
  } state_e;

  state_e      state_q;
  logic [7:0]  commaCnt_q;
  logic [3:0]  budget_q;
  logic        linkUp_q;

  logic        anyErr, isIdle, isData, isBad, forceLoss;

  logic [31:0] mem_q [Depth];
  logic [FIFO_DEPTH_LOG2-1:0] rdPtr_q, wrPtr_q;
  logic [FIFO_DEPTH_LOG2:0]   count_q;
  logic        full, pop, pushReq, push;

  logic [TimerW-1:0] timer_q;
  logic              rstReq_q;

  // Word classification: an idle is a K28.5 in byte 0 only, upper bytes ignored
  assign anyErr    = (|rx_disperr_in) | (|rx_encerr_in);
  assign isIdle    = !anyErr && (rx_charisk_in == 4'b0001) && (rx_data_in[7:0] == 8'hBC);
  assign isData    = !anyErr && (rx_charisk_in == 4'b0000);
  assign isBad     = !(isIdle || isData);
  assign forceLoss = rx_bufstatus_in | ~rx_reset_done_in;

  // Sync FSM: comma counting in ACQUIRE, leaky error budget in SYNC
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q    <= StLoss;
      commaCnt_q <= '0;
      budget_q   <= '0;
      linkUp_q   <= 1'b0;
    end else if (forceLoss) begin
      state_q    <= StLoss;
      commaCnt_q <= '0;
      budget_q   <= '0;
      linkUp_q   <= 1'b0;
    end else begin
      case (state_q)
        StLoss: begin
          if (isIdle) begin
            if (SYNC_COMMA_CNT == 1) begin
              state_q  <= StSync;
              budget_q <= '0;
              linkUp_q <= 1'b1;
            end else begin
              state_q    <= StAcquire;
              commaCnt_q <= 8'd1;
            end
          end
        end
        StAcquire: begin
          if (isBad) begin
            state_q    <= StLoss;
            commaCnt_q <= '0;
          end else if (isData) begin
            commaCnt_q <= '0;
          end else if (commaCnt_q + 8'd1 == 8'(SYNC_COMMA_CNT)) begin
            state_q    <= StSync;
            commaCnt_q <= '0;
            budget_q   <= '0;
            linkUp_q   <= 1'b1;
          end else begin
            commaCnt_q <= commaCnt_q + 8'd1;
          end
        end
        StSync: begin
          if (isBad) begin
            if (budget_q + 4'd1 == 4'(LOS_ERR_THRESH)) begin
              state_q  <= StLoss;
              budget_q <= '0;
              linkUp_q <= 1'b0;
            end else begin
              budget_q <= budget_q + 4'd1;
            end
          end else if (budget_q != 4'd0) begin
            budget_q <= budget_q - 4'd1;
          end
        end
        default: begin
          state_q    <= StLoss;
          commaCnt_q <= '0;
          budget_q   <= '0;
          linkUp_q   <= 1'b0;
        end
      endcase
    end
  end

  assign state_out   = state_q;
  assign link_up_out = linkUp_q;

  // Push uses the registered state, so a data word arriving with a
  // force-loss condition is still forwarded; a full FIFO accepts only
  // when the head is popped in the same cycle
  assign full    = (count_q == (FIFO_DEPTH_LOG2 + 1)'(Depth));
  assign vld_out = (count_q != '0);
  assign pop     = vld_out & rdy_in;
  assign pushReq = isData && (state_q == StSync);
  assign push    = pushReq && (!full || pop);

  // Data FIFO storage and pointers; the head is read combinationally
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        mem_q[wrPtr_q] <= rx_data_in;
        wrPtr_q        <= wrPtr_q + 1'b1;
      end
      if (pop) rdPtr_q <= rdPtr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign data_out = mem_q[rdPtr_q];

  // Datapath reset timer: one-cycle request after RESET_TIMEOUT LOSS cycles
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      timer_q  <= '0;
      rstReq_q <= 1'b0;
    end else begin
      rstReq_q <= 1'b0;
      if ((state_q == StLoss) && rx_reset_done_in) begin
        if (timer_q == TimerW'(RESET_TIMEOUT - 1)) begin
          timer_q  <= '0;
          rstReq_q <= 1'b1;
        end else begin
          timer_q <= timer_q + 1'b1;
        end
      end else begin
        timer_q <= '0;
      end
    end
  end

  assign rx_reset_datapath_out = rstReq_q;

`ifdef HSSL_RX_STATS_EN
  logic [15:0] errCnt_q, dropCnt_q;
  logic        drop;

  assign drop = pushReq && !push;

  // Saturating statistics: bad words in any state, words lost to a full FIFO
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      errCnt_q  <= '0;
      dropCnt_q <= '0;
    end else begin
      if (isBad && (errCnt_q != 16'hFFFF)) errCnt_q <= errCnt_q + 16'd1;
      if (drop && (dropCnt_q != 16'hFFFF)) dropCnt_q <= dropCnt_q + 16'd1;
    end
  end

  assign err_cnt_out  = errCnt_q;
  assign drop_cnt_out = dropCnt_q;
`else
  assign err_cnt_out  = '0;
  assign drop_cnt_out = '0;
`endif

endmodule

// File: tb/tb_hssl_rx_link_sync.sv
// tb_hssl_rx_link_sync: table-driven vectors for sync/word-class behaviour,
// hand-written sequences for FIFO, reset-request and async-reset corners,
// and a scoreboard queue for forwarded data words.
module tb_hssl_rx_link_sync;

  localparam int TimeoutCycles = 16;
`ifdef HSSL_RX_STATS_EN
  localparam bit StatsEn = 1'b1;
`else
  localparam bit StatsEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] rxData;
  logic [3:0]  rxCharisk, rxDisperr, rxEncerr;
  logic        rxBufstatus, rxResetDone, rdy;
  logic        rstReq, vld, linkUp;
  logic [31:0] dataOut;
  logic [1:0]  state;
  logic [15:0] errCnt, dropCnt;

  int checks = 0;
  int errors = 0;
  logic [31:0] sbQ[$];

  typedef struct {
    logic [31:0] data;
    logic [3:0]  k;
    logic [3:0]  dispErr;
    logic [3:0]  encErr;
    logic        push;
    logic [1:0]  expState;
    logic        expLinkUp;
    logic [15:0] expErr;
  } vec_t;

  vec_t vecs[$];

  hssl_rx_link_sync #(
    .SYNC_COMMA_CNT (8),
    .LOS_ERR_THRESH (4),
    .RESET_TIMEOUT  (TimeoutCycles),
    .FIFO_DEPTH_LOG2(2)
  ) dut (
    .clk_in               (clk),
    .reset_n_in           (reset_n),
    .rx_data_in           (rxData),
    .rx_charisk_in        (rxCharisk),
    .rx_disperr_in        (rxDisperr),
    .rx_encerr_in         (rxEncerr),
    .rx_bufstatus_in      (rxBufstatus),
    .rx_reset_done_in     (rxResetDone),
    .rx_reset_datapath_out(rstReq),
    .data_out             (dataOut),
    .vld_out              (vld),
    .rdy_in               (rdy),
    .link_up_out          (linkUp),
    .state_out            (state),
    .err_cnt_out          (errCnt),
    .drop_cnt_out         (dropCnt)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic [31:0] d, logic [3:0] k, logic [3:0] de, logic [3:0] ee,
                              logic p, logic [1:0] st, logic lu, logic [15:0] er);
    vec_t v;
    v.data = d; v.k = k; v.dispErr = de; v.encErr = ee;
    v.push = p; v.expState = st; v.expLinkUp = lu; v.expErr = er;
    return v;
  endfunction

  task automatic checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(logic [31:0] d, logic [3:0] k, logic [3:0] de, logic [3:0] ee);
    rxData    = d;
    rxCharisk = k;
    rxDisperr = de;
    rxEncerr  = ee;
    @(posedge clk);
    #1;
  endtask

  task automatic sendIdle();
    applyStimulus(32'h000000BC, 4'b0001, 4'b0000, 4'b0000);
  endtask

  task automatic sendData(logic [31:0] d);
    applyStimulus(d, 4'b0000, 4'b0000, 4'b0000);
  endtask

  task automatic reachSync();
    for (int i = 0; i < 8; i++) sendIdle();
    checkOutput("reach_sync_state", {30'd0, state}, 32'd2);
  endtask

  task automatic resetDut();
    reset_n     = 1'b0;
    rxData      = '0;
    rxCharisk   = '0;
    rxDisperr   = '0;
    rxEncerr    = '0;
    rxBufstatus = 1'b0;
    rxResetDone = 1'b1;
    rdy         = 1'b1;
    repeat (2) @(posedge clk);
    sbQ.delete();
    @(negedge clk);
    reset_n = 1'b1;
    #1;
  endtask

  // Scoreboard: every accepted handshake must match the oldest expected word
  always @(negedge clk) begin
    if (reset_n && vld && rdy) begin
      if (sbQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_word: got %0h, expected no output", dataOut);
      end else begin
        automatic logic [31:0] exp = sbQ.pop_front();
        checkOutput("fifo_data", dataOut, exp);
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cnt;
    logic expPulse;

    // Vector table: sync acquisition, word classes, comma reset, leaky budget
    for (int i = 0; i < 7; i++)
      vecs.push_back(mk((i == 2) ? 32'hFFFFFFBC : 32'h000000BC, 4'b0001, 0, 0, 0, 2'b01, 0, 0));
    vecs.push_back(mk(32'h000000BC, 4'b0001, 0, 0, 0, 2'b10, 1, 0));
    vecs.push_back(mk(32'h11111111, 4'b0000, 0, 0, 1, 2'b10, 1, 0));
    vecs.push_back(mk(32'h22222222, 4'b0000, 0, 0, 1, 2'b10, 1, 0));
    vecs.push_back(mk(32'h33333333, 4'b0000, 4'b0010, 0, 0, 2'b10, 1, 1));
    vecs.push_back(mk(32'h33333333, 4'b0000, 4'b0010, 0, 0, 2'b10, 1, 2));
    vecs.push_back(mk(32'h33333333, 4'b0000, 4'b0010, 0, 0, 2'b10, 1, 3));
    vecs.push_back(mk(32'h33333333, 4'b0000, 4'b0010, 0, 0, 2'b00, 0, 4));
    vecs.push_back(mk(32'h0000007C, 4'b0001, 0, 0, 0, 2'b00, 0, 5));
    vecs.push_back(mk(32'h0000BC00, 4'b0010, 0, 0, 0, 2'b00, 0, 6));
    vecs.push_back(mk(32'h000000BC, 4'b0001, 0, 4'b0100, 0, 2'b00, 0, 7));
    vecs.push_back(mk(32'h000000BC, 4'b0001, 0, 0, 0, 2'b01, 0, 7));
    vecs.push_back(mk(32'h000000BC, 4'b0001, 0, 0, 0, 2'b01, 0, 7));
    vecs.push_back(mk(32'h44444444, 4'b0000, 0, 0, 0, 2'b01, 0, 7));
    for (int i = 0; i < 7; i++)
      vecs.push_back(mk(32'h000000BC, 4'b0001, 0, 0, 0, 2'b01, 0, 7));
    vecs.push_back(mk(32'h000000BC, 4'b0001, 0, 0, 0, 2'b10, 1, 7));
    vecs.push_back(mk(32'hBCBCBCBC, 4'b1111, 0, 0, 0, 2'b10, 1, 8));
    vecs.push_back(mk(32'h000000BC, 4'b0001, 0, 0, 0, 2'b10, 1, 8));
    vecs.push_back(mk(32'h66666666, 4'b0000, 0, 4'b0001, 0, 2'b10, 1, 9));
    vecs.push_back(mk(32'h66666666, 4'b0000, 0, 4'b0001, 0, 2'b10, 1, 10));
    vecs.push_back(mk(32'h66666666, 4'b0000, 0, 4'b0001, 0, 2'b10, 1, 11));
    vecs.push_back(mk(32'h55555555, 4'b0000, 0, 0, 1, 2'b10, 1, 11));
    vecs.push_back(mk(32'h66666666, 4'b0000, 4'b1000, 0, 0, 2'b10, 1, 12));
    vecs.push_back(mk(32'h66666666, 4'b0000, 4'b1000, 0, 0, 2'b00, 0, 13));

    // Reset state
    resetDut();
    checkOutput("reset_state", {30'd0, state}, 32'd0);
    checkOutput("reset_vld", {31'd0, vld}, 32'd0);
    checkOutput("reset_data", dataOut, 32'd0);
    checkOutput("reset_link_up", {31'd0, linkUp}, 32'd0);
    checkOutput("reset_rst_req", {31'd0, rstReq}, 32'd0);
    checkOutput("reset_err_cnt", {16'd0, errCnt}, 32'd0);
    checkOutput("reset_drop_cnt", {16'd0, dropCnt}, 32'd0);

    // Table-driven vectors
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].push) sbQ.push_back(vecs[i].data);
      applyStimulus(vecs[i].data, vecs[i].k, vecs[i].dispErr, vecs[i].encErr);
      checkOutput($sformatf("vec%0d_state", i), {30'd0, state}, {30'd0, vecs[i].expState});
      checkOutput($sformatf("vec%0d_link_up", i), {31'd0, linkUp}, {31'd0, vecs[i].expLinkUp});
      checkOutput($sformatf("vec%0d_err_cnt", i), {16'd0, errCnt},
                  StatsEn ? {16'd0, vecs[i].expErr} : 32'd0);
    end
    sendData(32'h0);
    sendData(32'h0);
    checkOutput("table_sb_empty", sbQ.size(), 32'd0);

    // FIFO fill with downstream stalled, drops, hold, full+pop push, drain
    resetDut();
    reachSync();
    rdy = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i < 4) sbQ.push_back(32'hA0 + i);
      sendData(32'hA0 + i);
    end
    checkOutput("full_drop_cnt", {16'd0, dropCnt}, StatsEn ? 32'd2 : 32'd0);
    checkOutput("full_vld", {31'd0, vld}, 32'd1);
    checkOutput("full_head", dataOut, 32'hA0);
    sendIdle();
    sendIdle();
    checkOutput("stall_hold_head", dataOut, 32'hA0);
    checkOutput("stall_state", {30'd0, state}, 32'd2);
    rdy = 1'b1;
    sbQ.push_back(32'hA6);
    sendData(32'hA6);
    checkOutput("full_pop_push_drop_cnt", {16'd0, dropCnt}, StatsEn ? 32'd2 : 32'd0);
    checkOutput("after_pop_head", dataOut, 32'hA1);
    for (int i = 0; i < 6; i++) sendIdle();
    checkOutput("drain_vld", {31'd0, vld}, 32'd0);
    checkOutput("drain_sb_empty", sbQ.size(), 32'd0);

    // Datapath reset request timing in LOSS, including a reset_done drop
    resetDut();
    cnt = 0;
    for (int i = 0; i < 61; i++) begin
      rxResetDone = (i != 40);
      sendData(32'h0);
      cnt = rxResetDone ? cnt + 1 : 0;
      expPulse = rxResetDone && (cnt != 0) && (cnt % TimeoutCycles == 0);
      checkOutput($sformatf("rst_req_cycle%0d", i), {31'd0, rstReq}, {31'd0, expPulse});
    end
    rxResetDone = 1'b1;
    checkOutput("timer_state", {30'd0, state}, 32'd0);

    // Buffer error in SYNC: same-cycle data still pushed, next one is not
    resetDut();
    reachSync();
    rxBufstatus = 1'b1;
    sbQ.push_back(32'hB0);
    sendData(32'hB0);
    rxBufstatus = 1'b0;
    checkOutput("bufstatus_state", {30'd0, state}, 32'd0);
    checkOutput("bufstatus_link_up", {31'd0, linkUp}, 32'd0);
    sendData(32'hB1);
    checkOutput("post_loss_state", {30'd0, state}, 32'd0);
    sendData(32'h0);
    sendData(32'h0);
    checkOutput("bufstatus_vld", {31'd0, vld}, 32'd0);
    checkOutput("bufstatus_sb_empty", sbQ.size(), 32'd0);
    reachSync();
    rxResetDone = 1'b0;
    sendIdle();
    rxResetDone = 1'b1;
    checkOutput("reset_done_low_state", {30'd0, state}, 32'd0);

    // Asynchronous reset with words queued
    resetDut();
    reachSync();
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) sendData(32'hC0 + i);
    checkOutput("queued_vld", {31'd0, vld}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("async_vld", {31'd0, vld}, 32'd0);
    checkOutput("async_state", {30'd0, state}, 32'd0);
    checkOutput("async_link_up", {31'd0, linkUp}, 32'd0);
    checkOutput("async_data", dataOut, 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    rdy     = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      sendData(32'h0);
      checkOutput($sformatf("post_reset_vld%0d", i), {31'd0, vld}, 32'd0);
    end
    checkOutput("post_reset_drop_cnt", {16'd0, dropCnt}, 32'd0);
    checkOutput("final_sb_empty", sbQ.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
